// File: rtl/signed_divider.sv
// Sequential 17/9-bit two's-complement divider: magnitude restoring division
// over 17 iterations, then sign correction of quotient and remainder.
module signed_divider (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [16:0] dividend,
  input  logic [8:0]  divisor,
  output logic [16:0] quotient,
  output logic [8:0]  remainder,
  output logic        done,
  output logic        busy,
  output logic        div_zero,
  output logic        overflow,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DIVIDE = 3'd2,
    FIX    = 3'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [16:0] dividend_q;
  logic [8:0]  divisor_q;
  logic        sign_q;
  logic        sign_r;
  logic [16:0] q_reg;
  logic [8:0]  r_reg;
  logic [8:0]  d_mag;
  logic [4:0]  count;

  logic [16:0] dividend_mag;
  logic [8:0]  divisor_mag;
  logic [10:0] trial;
  logic [16:0] q_fix;
  logic [8:0]  r_fix;
  logic        q_ovf;

  // Magnitudes are unsigned, so -65536 and -256 map to 65536 and 256 exactly.
  assign dividend_mag = dividend_q[16] ? (~dividend_q + 17'd1) : dividend_q;
  assign divisor_mag  = divisor_q[8]   ? (~divisor_q + 9'd1)   : divisor_q;
  assign trial        = {1'b0, r_reg, q_reg[16]} - {2'b00, d_mag};
  assign q_fix        = sign_q ? (~q_reg + 17'd1) : q_reg;
  assign r_fix        = sign_r ? (~r_reg + 9'd1)  : r_reg;
  assign q_ovf        = !sign_q && (q_reg == 17'h10000);

  assign busy  = (state_q != IDLE);
  assign state = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = (divisor_q == 9'd0) ? IDLE : DIVIDE;
      DIVIDE:  state_d = (count == 5'd0) ? FIX : DIVIDE;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      q_reg      <= '0;
      r_reg      <= '0;
      d_mag      <= '0;
      count      <= '0;
      quotient   <= '0;
      remainder  <= '0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dividend_q <= dividend;
            divisor_q  <= divisor;
            sign_q     <= dividend[16] ^ divisor[8];
            sign_r     <= dividend[16];
          end
        end
        LOAD: begin
          if (divisor_q == 9'd0) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b1;
            overflow  <= 1'b0;
            done      <= 1'b1;
          end else begin
            q_reg <= dividend_mag;
            d_mag <= divisor_mag;
            r_reg <= '0;
            count <= 5'd16;
          end
        end
        DIVIDE: begin
          if (!trial[10]) begin
            r_reg <= trial[8:0];
            q_reg <= {q_reg[15:0], 1'b1};
          end else begin
            r_reg <= {r_reg[7:0], q_reg[16]};
            q_reg <= {q_reg[15:0], 1'b0};
          end
          count <= count - 5'd1;
        end
        FIX: begin
          // The lone overflow case (-65536 / -1) leaves q_reg = 17'h10000,
          // which is already the value to report.
          quotient  <= q_fix;
          remainder <= r_fix;
          overflow  <= q_ovf;
          div_zero  <= 1'b0;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: expected results are pushed when an
// operation is launched and popped by a monitor when done pulses.
module tb_signed_divider;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [16:0] dividend = '0;
  logic [8:0]  divisor = '0;
  logic [16:0] quotient;
  logic [8:0]  remainder;
  logic        done;
  logic        busy;
  logic        div_zero;
  logic        overflow;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [16:0] q;
    logic [8:0]  r;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];

  signed_divider dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .state     (state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [16:0] a, input logic [8:0] b);
    exp_t e;
    int sa;
    int sb;
    int qi;
    int ri;
    sa = $signed(a);
    sb = $signed(b);
    e.dz = 1'b0;
    e.ov = 1'b0;
    if (sb == 0) begin
      e.q  = '0;
      e.r  = '0;
      e.dz = 1'b1;
    end else if (sa == -65536 && sb == -1) begin
      e.q  = 17'h10000;
      e.r  = '0;
      e.ov = 1'b1;
    end else begin
      qi  = sa / sb;
      ri  = sa % sb;
      e.q = qi[16:0];
      e.r = ri[8:0];
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset_n && done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("overflow", 32'(overflow), 32'(e.ov));
      end
    end
  end

  // Called with inputs safely away from the rising edge; the next rising
  // edge is E0. Returns at #1 after the edge on which done was registered.
  // When mess is set, start and the operands are scrambled during DIVIDE.
  task automatic do_op(input logic [16:0] a, input logic [8:0] b, input bit mess);
    int n;
    int lat;
    lat = (b == 9'd0) ? 1 : 19;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb_q.push_back(model(a, b));
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    n = 1;
    while (!done && n <= 40) begin
      if (mess && n == 5) begin
        dividend = 17'($urandom);
        divisor  = 9'($urandom);
        start    = 1'b1;
      end
      if (n == 8) start = 1'b0;
      @(posedge clock);
      #1;
      if (!done) n++;
    end
    start = 1'b0;
    chk("latency", 32'(n), 32'(lat));
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_flags", {28'd0, done, busy, div_zero, overflow}, 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    do_op(17'd7, 9'd2, 0);
    @(negedge clock);
    do_op(-17'sd7, 9'd2, 0);
    @(negedge clock);
    do_op(17'd7, -9'sd2, 0);
    @(negedge clock);
    do_op(17'd65535, -9'sd256, 0);
    @(negedge clock);
    do_op(17'h10000, -9'sd1, 0);
    @(negedge clock);
    do_op(17'd100, 9'd0, 0);
    @(negedge clock);
    do_op(17'd5, 9'd3, 0);
    @(negedge clock);
    do_op(17'd1000, -9'sd7, 1);
    do_op(-17'sd300, 9'd17, 0);
    do_op(17'h10000, 9'd1, 0);
    do_op(17'h10000, -9'sd256, 0);
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      do_op(17'($urandom), 9'($urandom_range(511, 1)), 0);
      @(negedge clock);
    end

    // Leave a nonzero result in place, then abort an operation mid-DIVIDE.
    do_op(17'd1234, 9'd5, 0);
    @(negedge clock);
    dividend = 17'd999;
    divisor  = 9'd3;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_flags", {28'd0, done, busy, div_zero, overflow}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    do_op(17'h1FFFF, 9'h1FF, 0);

    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
